// File: rtl/dp_pkg.sv
// dp_pkg: shared Q8.8 constants and helpers for the dot-product engine.
package dp_pkg;
  localparam int IN_W = 16;
  localparam int IN_FRAC = 8;
  localparam int PROD_W = 32;
  localparam int OUT_FRAC = 16;
  function automatic int tree_levels(input int n);
    return $clog2(n);
  endfunction
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    return value > hi ? hi : value < lo ? lo : value;
  endfunction
endpackage

// File: rtl/dp_adder_tree_pipe.sv
// dp_adder_tree_pipe: pipelined exact pairwise adder tree, one registered level per log2 step.
module dp_adder_tree_pipe import dp_pkg::*; #(
  parameter int N = 49,
  parameter int IN_W = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                adv,
  input  logic                                in_valid,
  input  logic                                in_last,
  input  logic [N*IN_W-1:0]                   in_flat,
  output logic [IN_W+tree_levels(N)-1:0]      sum,
  output logic                                valid,
  output logic                                last
);
  localparam int L = tree_levels(N);
  localparam int OW = IN_W + L;
  localparam int LD = L > 0 ? L : 1;
  function automatic int cnt_at(input int k);
    return (N + (1 << k) - 1) >> k;
  endfunction
  logic signed [OW-1:0] src [N];
  logic signed [OW-1:0] lvl_d [LD][N];
  logic signed [OW-1:0] lvl_q [LD][N];
  logic [LD-1:0] vld_d, vld_q, lst_d, lst_q;
  always_comb begin
    int ia, ib, km;
    logic signed [OW-1:0] pa, pb;
    ia = 0;
    ib = 0;
    km = 0;
    pa = '0;
    pb = '0;
    for (int i = 0; i < N; i++) src[i] = OW'($signed(in_flat[i*IN_W +: IN_W]));
    for (int k = 0; k < LD; k++)
      for (int i = 0; i < N; i++) begin
        ia = 2 * i < N ? 2 * i : N - 1;
        ib = 2 * i + 1 < N ? 2 * i + 1 : N - 1;
        km = k > 0 ? k - 1 : 0;
        pa = k == 0 ? src[ia] : lvl_q[km][ia];
        pb = k == 0 ? src[ib] : lvl_q[km][ib];
        // an odd leftover lane simply passes through to the next level
        lvl_d[k][i] = i >= cnt_at(k + 1) ? '0 : 2 * i + 1 < cnt_at(k) ? pa + pb : pa;
      end
    vld_d = (vld_q << 1) | LD'(in_valid);
    lst_d = (lst_q << 1) | LD'(in_last);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
      lst_q <= lst_d;
    end
  end
  always_ff @(posedge clk) if (adv) lvl_q <= lvl_d;
  if (L == 0) begin : g_pass
    assign sum = src[0];
    assign valid = in_valid;
    assign last = in_last;
  end else begin : g_tree
    assign sum = lvl_q[L-1][0];
    assign valid = vld_q[L-1];
    assign last = lst_q[L-1];
  end
endmodule

// File: rtl/dot_product_engine.sv
// dot_product_engine: N-lane Q8.8 multiply, pipelined reduction and per-vector
// accumulation into a saturated Q(OUT_W-16).16 result with valid/ready on both sides.
module dot_product_engine import dp_pkg::*; #(
  parameter int N = 49,
  parameter int MAX_BEATS = 256,
  parameter int OUT_W = 38
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [N*16-1:0]              A_pack,
  input  logic [N*16-1:0]              B_pack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_ovf,
  output logic [$clog2(MAX_BEATS):0]   out_beats
);
  localparam int L = tree_levels(N);
  localparam int TW = PROD_W + L;
  localparam int CW = $clog2(MAX_BEATS) + 1;
  localparam int ACC_W = TW + $clog2(MAX_BEATS);
  logic adv, load;
  logic [N*PROD_W-1:0] prod_d, prod_q;
  logic pv_q, pl_q;
  logic [TW-1:0] t_sum;
  logic t_valid, t_last;
  logic signed [ACC_W-1:0] acc_d, acc_q, acc_sum;
  logic [CW-1:0] cnt_d, cnt_q, cnt_inc;
  logic bovf_d, bovf_q, bovf_inc;
  logic signed [63:0] sat_v;
  logic sat_hit;
  logic out_valid_d, out_valid_q, out_ovf_d, out_ovf_q;
  logic [OUT_W-1:0] out_data_d, out_data_q;
  logic [CW-1:0] out_beats_d, out_beats_q;
  always_comb begin
    adv = en && !(out_valid_q && !out_ready);
    in_ready = adv && !rst;
    for (int i = 0; i < N; i++)
      prod_d[i*PROD_W +: PROD_W] = $signed(A_pack[i*IN_W +: IN_W]) * $signed(B_pack[i*IN_W +: IN_W]);
    acc_sum = acc_q + ACC_W'($signed(t_sum));
    cnt_inc = cnt_q == CW'(MAX_BEATS) ? cnt_q : cnt_q + 1'b1;
    bovf_inc = bovf_q || cnt_q == CW'(MAX_BEATS);
    sat_v = sat_to_w(64'(acc_sum), OUT_W);
    sat_hit = sat_v != 64'(acc_sum);
    load = adv && t_valid && t_last;
    // the last beat of a vector hands its totals to the output and restarts from zero
    acc_d = !(adv && t_valid) ? acc_q : t_last ? '0 : acc_sum;
    cnt_d = !(adv && t_valid) ? cnt_q : t_last ? '0 : cnt_inc;
    bovf_d = !(adv && t_valid) ? bovf_q : t_last ? 1'b0 : bovf_inc;
    out_valid_d = load || (out_valid_q && !out_ready);
    out_data_d = load ? OUT_W'(sat_v) : out_data_q;
    out_ovf_d = load ? sat_hit || bovf_inc : out_ovf_q;
    out_beats_d = load ? cnt_inc : out_beats_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= 1'b0;
      pl_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      bovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ovf_q <= 1'b0;
      out_beats_q <= '0;
    end else begin
      if (adv) begin
        pv_q <= in_valid && in_ready;
        pl_q <= in_last;
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      bovf_q <= bovf_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ovf_q <= out_ovf_d;
      out_beats_q <= out_beats_d;
    end
  end
  always_ff @(posedge clk) if (adv) prod_q <= prod_d;
  dp_adder_tree_pipe #(.N(N), .IN_W(PROD_W)) u_tree (
    .clk(clk),
    .rst(rst),
    .adv(adv),
    .in_valid(pv_q),
    .in_last(pl_q),
    .in_flat(prod_q),
    .sum(t_sum),
    .valid(t_valid),
    .last(t_last)
  );
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ovf = out_ovf_q;
  assign out_beats = out_beats_q;
endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine: directed-vector bench for the 49-lane engine with hand-computed results.
module tb_dot_product_engine;
  localparam int N = 49;
  localparam logic [37:0] D98 = 38'h0000620000;
  localparam logic [37:0] D294 = 38'h0001260000;
  localparam logic [37:0] DM98 = 38'h3FFF9E0000;
  localparam logic [37:0] DSAT = 38'h1FFFFFFFFF;
  localparam logic [37:0] D147 = 38'h0000930000;
  localparam logic [37:0] D196 = 38'h0000C40000;
  logic clk = 0, rst = 1, en = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [N*16-1:0] A_pack = '0, B_pack = '0;
  logic in_ready, out_valid, out_ovf;
  logic [37:0] out_data;
  logic [8:0] out_beats;
  int checks = 0, failures = 0, n;
  logic [37:0] q_data[$];
  logic q_ovf[$];
  logic [8:0] q_beats[$];
  logic [37:0] d;
  logic o;
  logic [8:0] b;
  dot_product_engine #(.N(N), .MAX_BEATS(256), .OUT_W(38)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .A_pack(A_pack), .B_pack(B_pack), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_beats(out_beats)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_ovf.push_back(out_ovf);
      q_beats.push_back(out_beats);
    end
  task automatic send_beat(input logic [15:0] a, input logic [15:0] bb, input logic last);
    for (int i = 0; i < N; i++) begin
      A_pack[i*16 +: 16] = a;
      B_pack[i*16 +: 16] = bb;
    end
    in_valid = 1;
    in_last = last;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last = 0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_beat: in_ready stayed 0 for 300 cycles, required 1");
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic get_result();
    bit ok;
    ok = 0;
    d = '0;
    o = 0;
    b = '0;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (q_data.size() > 0) begin
        d = q_data.pop_front();
        o = q_ovf.pop_front();
        b = q_beats.pop_front();
        ok = 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    idle(3);
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_data !== 38'h0) begin failures++; $display("FAIL reset_data: got %h want 0", out_data); end
    if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
    if (out_beats !== 9'd0) begin failures++; $display("FAIL reset_beats: got %0d want 0", out_beats); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 0;
    idle(1);
  endtask
  task automatic test_single();
    send_beat(16'h0100, 16'h0200, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    get_result();
    checks += 4;
    if (n !== 7) begin failures++; $display("FAIL single_latency: got %0d edges want 7", n); end
    if (d !== D98) begin failures++; $display("FAIL single_data: got %h want %h", d, D98); end
    if (b !== 9'd1) begin failures++; $display("FAIL single_beats: got %0d want 1", b); end
    if (o !== 1'b0) begin failures++; $display("FAIL single_ovf: got %b want 0", o); end
  endtask
  task automatic test_back_to_back();
    idle(12);
    send_beat(16'h0100, 16'h0200, 0);
    send_beat(16'h0100, 16'h0200, 0);
    send_beat(16'h0100, 16'h0200, 1);
    send_beat(16'hFF00, 16'h0200, 1);
    get_result();
    checks += 3;
    if (d !== D294) begin failures++; $display("FAIL b2b_first_data: got %h want %h", d, D294); end
    if (b !== 9'd3) begin failures++; $display("FAIL b2b_first_beats: got %0d want 3", b); end
    if (o !== 1'b0) begin failures++; $display("FAIL b2b_first_ovf: got %b want 0", o); end
    get_result();
    checks += 2;
    if (d !== DM98) begin failures++; $display("FAIL b2b_second_data: got %h want %h", d, DM98); end
    if (b !== 9'd1) begin failures++; $display("FAIL b2b_second_beats: got %0d want 1", b); end
  endtask
  task automatic test_saturation();
    idle(12);
    for (int k = 0; k < 3; k++) send_beat(16'h8000, 16'h8000, k == 2);
    get_result();
    checks += 3;
    if (d !== DSAT) begin failures++; $display("FAIL sat_data: got %h want %h", d, DSAT); end
    if (o !== 1'b1) begin failures++; $display("FAIL sat_ovf: got %b want 1", o); end
    if (b !== 9'd3) begin failures++; $display("FAIL sat_beats: got %0d want 3", b); end
  endtask
  task automatic test_backpressure();
    idle(12);
    out_ready = 0;
    fork
      begin
        send_beat(16'h0100, 16'h0200, 1);
        send_beat(16'h0300, 16'h0100, 1);
        send_beat(16'h0100, 16'hFF00, 0);
        send_beat(16'h0100, 16'hFF00, 1);
        send_beat(16'h0100, 16'h0200, 1);
      end
      begin
        for (int t = 0; t < 40 && !out_valid; t++) idle(1);
        idle(10);
        checks += 4;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_held: got %b want 1", out_valid); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        if (out_data !== D98) begin failures++; $display("FAIL bp_data_stable: got %h want %h", out_data, D98); end
        if (q_data.size() !== 0) begin failures++; $display("FAIL bp_no_handshake: got %0d results want 0", q_data.size()); end
        out_ready = 1;
      end
    join
    get_result();
    checks += 2;
    if (d !== D98) begin failures++; $display("FAIL bp_r0_data: got %h want %h", d, D98); end
    if (b !== 9'd1) begin failures++; $display("FAIL bp_r0_beats: got %0d want 1", b); end
    get_result();
    checks += 2;
    if (d !== D147) begin failures++; $display("FAIL bp_r1_data: got %h want %h", d, D147); end
    if (b !== 9'd1) begin failures++; $display("FAIL bp_r1_beats: got %0d want 1", b); end
    get_result();
    checks += 2;
    if (d !== DM98) begin failures++; $display("FAIL bp_r2_data: got %h want %h", d, DM98); end
    if (b !== 9'd2) begin failures++; $display("FAIL bp_r2_beats: got %0d want 2", b); end
    get_result();
    checks += 2;
    if (d !== D98) begin failures++; $display("FAIL bp_r3_data: got %h want %h", d, D98); end
    if (b !== 9'd1) begin failures++; $display("FAIL bp_r3_beats: got %0d want 1", b); end
  endtask
  task automatic test_reset_mid_vector();
    idle(12);
    send_beat(16'h0100, 16'h0200, 0);
    send_beat(16'h0100, 16'h0200, 0);
    rst = 1;
    idle(1);
    rst = 0;
    send_beat(16'h0100, 16'h0200, 1);
    get_result();
    checks += 2;
    if (d !== D98) begin failures++; $display("FAIL rstmid_data: got %h want %h", d, D98); end
    if (b !== 9'd1) begin failures++; $display("FAIL rstmid_beats: got %0d want 1", b); end
    idle(20);
    checks++;
    if (q_data.size() !== 0) begin failures++; $display("FAIL rstmid_extra: got %0d extra results want 0", q_data.size()); end
  endtask
  task automatic test_en_gap();
    idle(12);
    send_beat(16'h0100, 16'h0200, 0);
    en = 0;
    idle(3);
    en = 1;
    send_beat(16'h0100, 16'h0200, 1);
    get_result();
    checks += 2;
    if (d !== D196) begin failures++; $display("FAIL engap_data: got %h want %h", d, D196); end
    if (b !== 9'd2) begin failures++; $display("FAIL engap_beats: got %0d want 2", b); end
    idle(12);
    send_beat(16'h0100, 16'h0200, 1);
    en = 0;
    idle(3);
    en = 1;
    n = 3;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    get_result();
    checks += 2;
    if (n !== 10) begin failures++; $display("FAIL engap_latency: got %0d edges want 10", n); end
    if (d !== D98) begin failures++; $display("FAIL engap_lat_data: got %h want %h", d, D98); end
  endtask
  task automatic test_beat_limit();
    idle(12);
    for (int k = 0; k < 256; k++) send_beat(16'h0000, 16'h0200, k == 255);
    get_result();
    checks += 2;
    if (b !== 9'd256) begin failures++; $display("FAIL limit256_beats: got %0d want 256", b); end
    if (o !== 1'b0) begin failures++; $display("FAIL limit256_ovf: got %b want 0", o); end
    for (int k = 0; k < 257; k++) send_beat(16'h0000, 16'h0200, k == 256);
    get_result();
    checks += 3;
    if (b !== 9'd256) begin failures++; $display("FAIL limit257_beats: got %0d want 256", b); end
    if (o !== 1'b1) begin failures++; $display("FAIL limit257_ovf: got %b want 1", o); end
    if (d !== 38'h0) begin failures++; $display("FAIL limit257_data: got %h want 0", d); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_reset_mid_vector();
    test_en_gap();
    test_beat_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
